// File: rtl/mem_pkg.sv
// Shared memory-bus definitions used by the CPU and by mem_responder.
// Holds the command encoding and the default I/O register addresses.
package mem_pkg;

    // Memory command as issued by the CPU each cycle.
    typedef enum logic [1:0] {
        MNONE    = 2'b00,
        MREAD    = 2'b01,
        MWRITE   = 2'b10,
        MILLEGAL = 2'b11
    } mem_cmd_e;

    localparam int unsigned MEM_ADDR_W = 9;
    localparam int unsigned MEM_DATA_W = 16;

    // Default memory-mapped I/O register addresses (upper half of the map).
    localparam logic [MEM_ADDR_W-1:0] LED_ADDR_DEFAULT = 9'h100;
    localparam logic [MEM_ADDR_W-1:0] SW_ADDR_DEFAULT  = 9'h140;

endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> memory responder bus.
//   mem_cmd    : command (MNONE / MREAD / MWRITE / illegal)
//   mem_addr   : 9-bit word address
//   write_data : store data, sampled with MWRITE
//   read_data  : load data, valid one cycle after MREAD
//   read_valid : one-cycle pulse when read_data was updated
// master = CPU side, slave = responder side.
interface mem_responder_if;
    import mem_pkg::*;

    mem_cmd_e                mem_cmd;
    logic [MEM_ADDR_W-1:0]   mem_addr;
    logic [MEM_DATA_W-1:0]   write_data;
    logic [MEM_DATA_W-1:0]   read_data;
    logic                    read_valid;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  read_valid
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output read_valid
    );

endinterface

// File: rtl/ram_sp.sv
// Single-port RAM, synchronous write, registered read (read-before-write).
// Ports:
//   clk  : clock
//   we   : write enable
//   addr : word address
//   din  : write data
//   dout : registered read data of mem[addr] from the previous edge
module ram_sp #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are intentionally not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: decodes CPU commands and serves a 256x16 RAM,
// an LED output register and a synchronized switch input register.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_responder_if slave (cmd/addr/wdata in, rdata/valid out)
//   sw         : asynchronous switch inputs
//   leds       : LED register
//   fault      : sticky illegal-access flag, cleared only by reset
module mem_responder
    import mem_pkg::*;
#(
    parameter int                    RAM_WORDS = 256,
    parameter logic [MEM_ADDR_W-1:0] LED_ADDR  = LED_ADDR_DEFAULT,
    parameter logic [MEM_ADDR_W-1:0] SW_ADDR   = SW_ADDR_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    mem_responder_if.slave      bus,
    input  logic [7:0]          sw,
    output logic [7:0]          leds,
    output logic                fault
);

    // ---------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------
    logic                  is_read;
    logic                  is_write;
    logic                  hit_ram;
    logic                  hit_led;
    logic                  hit_sw;
    logic                  access_fault;
    logic                  ram_we;
    logic [MEM_DATA_W-1:0] io_rdata;
    logic [MEM_DATA_W-1:0] ram_dout;

    logic [7:0]            leds_reg;
    logic                  fault_reg;
    logic                  read_valid_reg;
    logic [MEM_DATA_W-1:0] hold_reg;
    logic                  sel_ram_reg;
    logic [7:0]            sw_meta_reg;
    logic [7:0]            sw_sync_reg;

    always_comb begin
        is_read  = (bus.mem_cmd == MREAD);
        is_write = (bus.mem_cmd == MWRITE);
        hit_ram  = ~bus.mem_addr[8];
        hit_led  = ~hit_ram && (bus.mem_addr == LED_ADDR);
        hit_sw   = ~hit_ram && (bus.mem_addr == SW_ADDR);

        // Illegal command, access to an unmapped address, or a store to
        // the read-only switch register.
        access_fault = (bus.mem_cmd == MILLEGAL)
                     || ((is_read || is_write) && !hit_ram && !hit_led && !hit_sw)
                     || (is_write && hit_sw);

        // Reset has priority: a store sampled during reset never lands.
        ram_we = is_write && hit_ram && !reset;

        io_rdata = '0;
        if (hit_led) begin
            io_rdata = {8'h00, leds_reg};
        end else if (hit_sw) begin
            io_rdata = {8'h00, sw_sync_reg};
        end
    end

    // ---------------------------------------------------------------
    // RAM
    // ---------------------------------------------------------------
    ram_sp #(
        .DEPTH (RAM_WORDS),
        .AW    (8),
        .DW    (MEM_DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (bus.mem_addr[7:0]),
        .din  (bus.write_data),
        .dout (ram_dout)
    );

    // ---------------------------------------------------------------
    // Switch synchronizer, two flops per bit
    // ---------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sw_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    sw_meta_reg[gi] <= 1'b0;
                    sw_sync_reg[gi] <= 1'b0;
                end else begin
                    sw_meta_reg[gi] <= sw[gi];
                    sw_sync_reg[gi] <= sw_meta_reg[gi];
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------
    // Output mux, LED register, fault flag
    // ---------------------------------------------------------------
    // The RAM output register re-reads mem[addr] every edge, so it is only
    // presented on read_data for the cycle right after a RAM read. On the
    // following edge its value is copied into hold_reg, which keeps
    // read_data stable until the next MREAD. I/O reads go straight into
    // hold_reg since their value is known at the sampling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_valid_reg <= 1'b0;
            hold_reg       <= '0;
            sel_ram_reg    <= 1'b0;
            leds_reg       <= 8'h00;
            fault_reg      <= 1'b0;
        end else begin
            read_valid_reg <= is_read;

            if (access_fault) begin
                fault_reg <= 1'b1;
            end

            if (is_write && hit_led) begin
                leds_reg <= bus.write_data[7:0];
            end

            if (is_read) begin
                if (hit_ram) begin
                    sel_ram_reg <= 1'b1;
                end else begin
                    sel_ram_reg <= 1'b0;
                    hold_reg    <= io_rdata;
                end
            end else if (sel_ram_reg) begin
                sel_ram_reg <= 1'b0;
                hold_reg    <= ram_dout;
            end
        end
    end

    assign bus.read_data  = sel_ram_reg ? ram_dout : hold_reg;
    assign bus.read_valid = read_valid_reg;
    assign leds           = leds_reg;
    assign fault          = fault_reg;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    import mem_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic [7:0] leds;
    logic       fault;

    mem_responder_if bus ();

    mem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .sw    (sw),
        .leds  (leds),
        .fault (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [15:0] last_rd;

    typedef struct {
        mem_cmd_e    cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic [7:0]  exp_leds;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One bus transaction: drive, clock, then check outputs 1 time unit later.
    task automatic do_cmd(input string name, input mem_cmd_e cmd, input logic [8:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rd,
                          input logic [7:0] exp_leds, input logic exp_fault);
        logic [15:0] e;
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = wdata;
        if (cmd == MREAD) exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        check({name, ".valid"}, {31'd0, bus.read_valid}, {31'd0, (cmd == MREAD)});
        if (bus.read_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check({name, ".unexpected_read"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                last_rd = e;
                check({name, ".rdata"}, {16'd0, bus.read_data}, {16'd0, e});
            end
        end else begin
            check({name, ".hold"}, {16'd0, bus.read_data}, {16'd0, last_rd});
        end
        check({name, ".leds"}, {24'd0, leds}, {24'd0, exp_leds});
        check({name, ".fault"}, {31'd0, fault}, {31'd0, exp_fault});
        $display("txn %s cmd=%0d addr=%h wdata=%h rdata=%h valid=%b leds=%h fault=%b",
                 name, cmd, addr, wdata, bus.read_data, bus.read_valid, leds, fault);
        bus.mem_cmd = MNONE;
    endtask

    // Hold reset for 3 edges with the given command presented on the first.
    task automatic do_reset(input string name, input mem_cmd_e cmd, input logic [8:0] addr,
                            input logic [15:0] wdata);
        reset          = 1'b1;
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = wdata;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.mem_cmd = MNONE;
            check({name, ".rdata"}, {16'd0, bus.read_data}, 32'd0);
            check({name, ".valid"}, {31'd0, bus.read_valid}, 32'd0);
            check({name, ".leds"}, {24'd0, leds}, 32'd0);
            check({name, ".fault"}, {31'd0, fault}, 32'd0);
        end
        reset = 1'b0;
        exp_q.delete();
        last_rd = 16'h0000;
        $display("txn %s reset released", name);
    endtask

    initial begin
        reset          = 1'b1;
        sw             = 8'h00;
        bus.mem_cmd    = MNONE;
        bus.mem_addr   = '0;
        bus.write_data = '0;
        last_rd        = 16'h0000;

        vecs[0]  = '{MWRITE, 9'h005, 16'h0007, 16'h0000, 8'h00, 1'b0};
        vecs[1]  = '{MREAD,  9'h005, 16'h0000, 16'h0007, 8'h00, 1'b0};
        vecs[2]  = '{MNONE,  9'h005, 16'h0000, 16'h0000, 8'h00, 1'b0};
        vecs[3]  = '{MWRITE, 9'h0FF, 16'hBEEF, 16'h0000, 8'h00, 1'b0};
        vecs[4]  = '{MREAD,  9'h0FF, 16'h0000, 16'hBEEF, 8'h00, 1'b0};
        vecs[5]  = '{MREAD,  9'h005, 16'h0000, 16'h0007, 8'h00, 1'b0};
        vecs[6]  = '{MWRITE, 9'h100, 16'hA55A, 16'h0000, 8'h5A, 1'b0};
        vecs[7]  = '{MREAD,  9'h100, 16'h0000, 16'h005A, 8'h5A, 1'b0};
        vecs[8]  = '{MWRITE, 9'h010, 16'h0000, 16'h0000, 8'h5A, 1'b0};
        vecs[9]  = '{MWRITE, 9'h0F0, 16'h1111, 16'h0000, 8'h5A, 1'b0};
        vecs[10] = '{MREAD,  9'h1F0, 16'h0000, 16'h0000, 8'h5A, 1'b1};
        vecs[11] = '{MWRITE, 9'h1F0, 16'h2222, 16'h0000, 8'h5A, 1'b1};
        vecs[12] = '{MREAD,  9'h0F0, 16'h0000, 16'h1111, 8'h5A, 1'b1};
        vecs[13] = '{MREAD,  9'h100, 16'h0000, 16'h005A, 8'h5A, 1'b1};

        @(negedge clk);
        do_reset("reset0", MNONE, 9'h000, 16'h0000);

        for (int i = 0; i < 14; i++) begin
            do_cmd($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, vecs[i].exp_leds, vecs[i].exp_fault);
        end

        // Clear fault, then exercise the switch synchronizer latency.
        do_reset("reset1", MNONE, 9'h000, 16'h0000);
        sw = 8'hC3;
        do_cmd("sw_edgeN",  MNONE, 9'h140, 16'h0000, 16'h0000, 8'h00, 1'b0);
        do_cmd("sw_early",  MREAD, 9'h140, 16'h0000, 16'h0000, 8'h00, 1'b0);
        do_cmd("sw_synced", MREAD, 9'h140, 16'h0000, 16'h00C3, 8'h00, 1'b0);

        // Store to the read-only switch register faults and changes nothing.
        do_cmd("sw_write",  MWRITE, 9'h140, 16'hFFFF, 16'h0000, 8'h00, 1'b1);
        do_cmd("sw_after",  MREAD,  9'h140, 16'h0000, 16'h00C3, 8'h00, 1'b1);

        // Illegal command encoding.
        do_reset("reset2", MNONE, 9'h000, 16'h0000);
        do_cmd("cmd11",     MILLEGAL, 9'h005, 16'h0000, 16'h0000, 8'h00, 1'b1);

        // Reset mid-operation: LED write and a RAM store coincide with reset.
        do_cmd("led_pre",   MWRITE, 9'h100, 16'h00FF, 16'h0000, 8'hFF, 1'b1);
        do_reset("reset3", MWRITE, 9'h010, 16'h1234);
        do_cmd("post_rst",  MREAD, 9'h010, 16'h0000, 16'h0000, 8'h00, 1'b0);
        do_cmd("post_idle", MNONE, 9'h010, 16'h0000, 16'h0000, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
